// File: rtl/detector_comida_pkg.sv
// Shared types and constants for the snake-game eat detector.
// The optional BCD score is enabled with the DETECTOR_SCORE_EN macro.
package detector_comida_pkg;

   localparam int PIX_W    = 11;
   localparam int DIFF_W   = PIX_W + 1;
   localparam int BCD_W    = 4;
   localparam int SCREEN_W = 800;
   localparam int SCREEN_H = 600;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_HIT       = 2'd1,
      ST_WAIT_MOVE = 2'd2,
      ST_COOLDOWN  = 2'd3
   } state_t;

   // Signed difference is 12 bits wide, so no wrap handling is needed at screen edges
   function automatic logic [DIFF_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
      logic [DIFF_W-1:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[DIFF_W-1]) begin
         abs_diff = ~d + DIFF_W'(1);
      end else begin
         abs_diff = d;
      end
   endfunction

endpackage

// File: rtl/detector_comida_contador_bcd.sv
// Three-digit BCD event counter that saturates at 999.
module contador_bcd
   import detector_comida_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   output logic [3*BCD_W-1:0]   count
);

   logic [3*BCD_W-1:0] count_q;
   logic [3*BCD_W-1:0] count_d;
   logic [BCD_W-1:0]   units_s;
   logic [BCD_W-1:0]   tens_s;
   logic [BCD_W-1:0]   hund_s;

   assign units_s = count_q[BCD_W-1:0];
   assign tens_s  = count_q[2*BCD_W-1:BCD_W];
   assign hund_s  = count_q[3*BCD_W-1:2*BCD_W];

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != 12'h999)) begin
         if (units_s != 4'd9) begin
            count_d = {hund_s, tens_s, units_s + 4'd1};
         end else if (tens_s != 4'd9) begin
            count_d = {hund_s, tens_s + 4'd1, 4'd0};
         end else begin
            count_d = {hund_s + 4'd1, 4'd0, 4'd0};
         end
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 12'h000;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/detector_comida.sv
// Eat detector: flags head/fruit overlap on each snake step, holds comer until the fruit moves.
// Define DETECTOR_SCORE_EN to include the BCD score counter; otherwise score reads 000.
module detector_comida
   import detector_comida_pkg::*;
#(
   parameter int FRUIT_BOX_WIDTH = 10,
   parameter int TIMEOUT_CYCLES  = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             head_step,
   input  logic [PIX_W-1:0] headX,
   input  logic [PIX_W-1:0] headY,
   input  logic [PIX_W-1:0] fruitPositionX,
   input  logic [PIX_W-1:0] fruitPositionY,
   output logic             comer,
   output logic             grow,
   output logic [11:0]      score
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t             state_q, state_d;
   logic               hit_q, hit_d;
   logic               step_q, step_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PIX_W-1:0]   fx_l_q, fx_l_d;
   logic [PIX_W-1:0]   fy_l_q, fy_l_d;
   logic               comer_q, comer_d;
   logic               grow_q, grow_d;
   logic               fruit_moved_s;

   always_comb begin
      step_d = head_step;
      hit_d  = hit_q;
      if (head_step) begin
         hit_d = (abs_diff(headX, fruitPositionX) < DIFF_W'(FRUIT_BOX_WIDTH)) &&
                 (abs_diff(headY, fruitPositionY) < DIFF_W'(FRUIT_BOX_WIDTH));
      end else begin
         hit_d = hit_q;
      end
   end

   assign fruit_moved_s = (fruitPositionX != fx_l_q) || (fruitPositionY != fy_l_q);

   always_comb begin
      state_d = state_q;
      comer_d = 1'b0;
      grow_d  = 1'b0;
      cnt_d   = cnt_q;
      fx_l_d  = fx_l_q;
      fy_l_d  = fy_l_q;
      case (state_q)
         ST_IDLE: begin
            if (step_q && hit_q) begin
               state_d = ST_HIT;
               comer_d = 1'b1;
               grow_d  = 1'b1;
               fx_l_d  = fruitPositionX;
               fy_l_d  = fruitPositionY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HIT: begin
            comer_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT_MOVE;
         end
         ST_WAIT_MOVE: begin
            if (fruit_moved_s) begin
               state_d = ST_COOLDOWN;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_COOLDOWN;
            end else begin
               comer_d = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_COOLDOWN: begin
            // Leave only once the head has stepped off whatever fruit is now present
            if (step_q && !hit_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_COOLDOWN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hit_q   <= 1'b0;
         step_q  <= 1'b0;
         cnt_q   <= '0;
         fx_l_q  <= '0;
         fy_l_q  <= '0;
         comer_q <= 1'b0;
         grow_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hit_q   <= hit_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         fx_l_q  <= fx_l_d;
         fy_l_q  <= fy_l_d;
         comer_q <= comer_d;
         grow_q  <= grow_d;
      end
   end

   assign comer = comer_q;
   assign grow  = grow_q;

`ifdef DETECTOR_SCORE_EN
   contador_bcd u_score (
      .clk   (clk),
      .rst   (rst),
      .inc   (grow_d),
      .count (score)
   );
`else
   assign score = 12'h000;
`endif

endmodule

// File: doc/detector_comida.md
# detector_comida

Eat detector for the snake game: compares the snake head position against the fruit position on every snake step and drives the `comer` request that the fruit generator consumes to relocate the fruit. Sits between the snake movement logic and the fruit generator. Also issues a one-cycle `grow` pulse to the snake body logic and keeps a BCD score for the display path.

## Interface
- `FRUIT_BOX_WIDTH`, 10: collision tolerance in pixels; overlap when |dx| < this and |dy| < this.
- `TIMEOUT_CYCLES`, 16: maximum cycles `comer` stays high waiting for the fruit to move.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `head_step`  in  1  one-cycle strobe: snake head has moved, `headX`/`headY` valid.
- `headX`  in  11  head centre X in pixels (0..799).
- `headY`  in  11  head centre Y in pixels (0..599).
- `fruitPositionX`  in  11  current fruit centre X from the fruit generator.
- `fruitPositionY`  in  11  current fruit centre Y from the fruit generator.
- `comer`  out  1  eat request to the fruit generator; level, registered.
- `grow`  out  1  one-cycle pulse per eaten fruit, to the snake body logic.
- `score`  out  12  three BCD digits [11:8] hundreds, [7:4] tens, [3:0] units.

## Operation
- Compare stage: on `head_step`, register `hit_q` = overlap(head, fruit) using 12-bit signed differences and absolute value. Register `step_q` = `head_step`. No comparison on non-step cycles.
- FSM states: IDLE, HIT, WAIT_MOVE, COOLDOWN.
- IDLE: `comer`=0. If `step_q` && `hit_q`: go to HIT, set `comer`=1, `grow`=1, increment score, latch `fruitPositionX/Y` into `fx_l/fy_l`.
- HIT: exactly one cycle. `grow` returns to 0. Clear timeout counter. Go to WAIT_MOVE.
- WAIT_MOVE: `comer`=1. If (`fruitPositionX`,`fruitPositionY`) != (`fx_l`,`fy_l`): go to COOLDOWN, `comer`=0. Else if timeout counter = `TIMEOUT_CYCLES`-1: go to COOLDOWN, `comer`=0. Else increment counter.
- COOLDOWN: `comer`=0. Stay until `step_q` && !`hit_q` (head stepped off the current fruit), then IDLE. This prevents double-counting when the fruit did not move or respawned under the head.
- Score: BCD increment, units carry to tens, tens to hundreds; saturates at 999 (stays 999, `grow` and `comer` still behave normally).
- `comer` is low for at least one cycle between two eats (guaranteed by COOLDOWN), so the fruit generator re-arms.

## Timing
- Reset values: `comer`=0, `grow`=0, `score`=12'h000, state IDLE, `hit_q`=0, `step_q`=0, counter 0, `fx_l`/`fy_l`=0.
- `rst` dominates every state; mid-operation reset drops `comer` on the next edge.
- Latency: `head_step` at edge E0; `comer`, `grow`, `score` update at E1 (visible after E1); `grow` clears at E2.
- Fruit change sampled in WAIT_MOVE: `comer` falls on the edge after the change is seen. Fruit changes during HIT are caught in the first WAIT_MOVE cycle because comparison is against the latched values.
- Timeout: with a stationary fruit, `comer` is high for 1 (HIT) + `TIMEOUT_CYCLES` cycles.
- `head_step` during HIT/WAIT_MOVE: compare stage still updates; the FSM ignores it.
- Boundary: dx exactly `FRUIT_BOX_WIDTH` is a miss; coordinates 0 and 799/599 need no wrap handling (signed difference).

## Configuration
- `DETECTOR_SCORE_EN` defined: BCD score counter present as described.
- Not defined: no score registers; `score` tied to 12'h000; `comer`/`grow` behaviour unchanged.

## Structure
- Shared package: FSM state encoding (2-bit), pixel width 11, BCD digit width 4, screen limits 800/600.
- One sub-module `contador_bcd`: 3-digit saturating BCD counter with `clk`, `rst`, `inc`, `count[11:0]`; instantiated only under `DETECTOR_SCORE_EN`.

## Test plan
- Reset: assert `rst` 2 cycles with arbitrary inputs -> `comer`=0, `grow`=0, `score`=000.
- Hit: head (395,295), fruit (395,295), `head_step` at E0 -> `comer`=1 and `grow`=1 after E1, `grow`=0 after E2, `score`=001; fruit to (125,45) at E3 -> `comer`=0 after E4.
- Near miss: head (405,295), fruit (395,295), `head_step` -> `comer` stays 0, `score` unchanged; head (404,295) -> hit.
- Timeout/no re-hit: fruit stays (395,295) -> `comer` high 17 cycles then 0; next `head_step` at (395,295) -> no hit; step to (405,295), then back to (395,295) -> hit, `score` +1.
- BCD: 10 hits from 000 -> `score`=12'h010; from 999, one hit -> `score`=999, `grow` still pulses.
- Reset mid-WAIT_MOVE -> `comer`=0 next edge, `score`=000, state IDLE.
